ll_op_arbiter: RTL and testbench
================================

// Module: ll_op_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer in front of the linked-list engine. Collects operation
//  requests (op + data) from NUM_REQ clients and grants one at a time. Issues a single-cycle
//  eng_start pulse to the engine, then holds the grant until the engine reports eng_done.
//  Returns a one-cycle completion pulse to the granted client.
// PARAMETERS
//  NUM_REQ      4    number of requesting clients (2..8)
//  OP_W         2    op-code width (push/pop/search/delete)
//  DATA_W       8    operand width
//  TIMEOUT_CYC  255  max WAIT cycles before abort (used only with LL_ARB_TIMEOUT_EN)
// PORTS
//  clk          in   1               system clock, all logic on posedge
//  reset        in   1               synchronous, active-high
//  req_valid    in   NUM_REQ         client i requests; held high until req_ready[i]
//  req_op       in   NUM_REQ*OP_W    client i op at [i*OP_W +: OP_W]; stable while valid
//  req_data     in   NUM_REQ*DATA_W  client i operand at [i*DATA_W +: DATA_W]; stable while valid
//  req_ready    out  NUM_REQ         one-cycle accept pulse to granted client
//  rsp_done     out  NUM_REQ         one-cycle completion pulse to granted client
//  eng_start    out  1               one-cycle start pulse to engine
//  eng_op       out  OP_W            registered op, valid from eng_start until completion
//  eng_data     out  DATA_W          registered operand, same validity as eng_op
//  eng_done     in   1               engine completion, single-cycle pulse
//  busy         out  1               high in ISSUE and WAIT
//  timeout_err  out  1               one-cycle abort pulse (constant 0 without macro)
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; eng_op/eng_data=0; last_grant=NUM_REQ-1 so client 0
//    wins first.
//  - FSM IDLE -> ISSUE -> WAIT -> IDLE.
//    IDLE: if any req_valid, pick first set bit searching from last_grant+1 with wrap
//      modulo NUM_REQ. Register the index as grant and latch its op/data. Go to ISSUE.
//      No request: stay in IDLE.
//    ISSUE (exactly 1 cycle): eng_start=1 and req_ready[grant]=1. last_grant<=grant. Go to WAIT.
//    WAIT: on eng_done, rsp_done[grant]=1 in the next cycle and the FSM returns to IDLE
//      in that same cycle.
//  - Latency: req_valid seen in IDLE at cycle N -> eng_start/req_ready at N+1.
//    eng_done at cycle M -> rsp_done at M+1. Earliest next eng_start is M+3.
//  - All outputs are registered. No combinational path from inputs to outputs.
//  - eng_done in IDLE or ISSUE is ignored; the engine never completes in its start cycle.
//  - req_valid may drop before req_ready only in IDLE of a non-granted client. Dropping it
//    while granted is a protocol error: flag with a bench assertion. The RTL still completes
//    normally on the latched op.
//  - A client may re-request from the cycle after its req_ready. Round-robin guarantees any
//    continuously requesting client is granted within NUM_REQ grants.
//  - Simultaneous eng_done and reset: reset wins, no rsp_done.
//  - Reset mid-WAIT: the grant is dropped and no rsp_done is issued. The engine must also
//    be reset, since it shares the same reset.
// CONFIGURATION
//  LL_ARB_TIMEOUT_EN defined:
//    - An 8..16-bit wait counter clears on ISSUE and increments every WAIT cycle.
//    - If it reaches TIMEOUT_CYC without eng_done: in the next cycle timeout_err=1 and
//      rsp_done[grant]=1, and the FSM goes to IDLE.
//    - eng_done arriving in the same cycle as the threshold counts as success; timeout_err
//      stays 0.
//  LL_ARB_TIMEOUT_EN undefined:
//    - No counter; WAIT is unbounded.
//    - timeout_err is tied to 0.
// TESTING
//  1 Single request: req_valid=4'b0010, op=2, data=8'hA5 at cycle 3.
//    -> eng_start and req_ready[1] at cycle 4; eng_op=2, eng_data=A5.
//    -> eng_done at cycle 9 -> rsp_done[1] at cycle 10; busy low at cycle 10.
//  2 All four clients request continuously, engine done 2 cycles after each start
//    -> grant order 0,1,2,3,0,1; exactly one eng_start per operation.
//  3 Client 2 is granted while 0 and 3 are waiting
//    -> next grants are 3 then 0 (wrap-around); client 2 is not regranted before them.
//  4 Reset asserted in WAIT of a client-1 operation
//    -> next cycle all outputs 0 and state IDLE; no rsp_done[1].
//    -> first post-reset grant goes to client 0 if it is requesting.
//  5 Stray eng_done in IDLE -> no rsp_done and no state change.
//  6 (LL_ARB_TIMEOUT_EN, TIMEOUT_CYC=10) engine never responds
//    -> timeout_err and rsp_done[grant] pulse 11 cycles after eng_start; FSM back in IDLE.
//    -> repeat with eng_done in the threshold cycle -> timeout_err=0.

Source files
------------

// File: rtl/ll_op_arbiter.sv
// ll_op_arbiter: round-robin arbiter/sequencer feeding one operation at a time to the linked-list engine.
// Optional WAIT abort counter enabled by defining LL_ARB_TIMEOUT_EN.
module ll_op_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int OP_W        = 2,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_done,
  output logic                      eng_start,
  output logic [OP_W-1:0]           eng_op,
  output logic [DATA_W-1:0]         eng_data,
  input  logic                      eng_done,
  output logic                      busy,
  output logic                      timeout_err
);
  localparam int IDX_W = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_nx;
  logic [IDX_W-1:0] grant, last_grant, pick, idx;
  logic found, launch, finish, tmo_hit;
  always_comb begin
    pick = '0;
    idx = '0;
    found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        pick = idx;
        found = 1'b1;
      end
    end
  end
  // the idle cycle carrying rsp_done is never used for arbitration
  assign launch = state == IDLE && found && !(|rsp_done);
  assign finish = state == WAIT && (eng_done || tmo_hit);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = launch ? ISSUE : IDLE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = finish ? IDLE : WAIT;
      default: state_nx = IDLE;
    endcase
  end
`ifdef LL_ARB_TIMEOUT_EN
  logic [15:0] wait_cnt;
  assign tmo_hit = state == WAIT && !eng_done && wait_cnt == 16'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk)
    if (reset) wait_cnt <= '0;
    else wait_cnt <= state == ISSUE ? '0 : state == WAIT ? wait_cnt + 16'd1 : wait_cnt;
`else
  assign tmo_hit = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      last_grant  <= IDX_W'(NUM_REQ - 1);
      req_ready   <= '0;
      rsp_done    <= '0;
      eng_start   <= 1'b0;
      eng_op      <= '0;
      eng_data    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      eng_start   <= launch;
      req_ready   <= launch ? NUM_REQ'(1) << pick : '0;
      rsp_done    <= finish ? NUM_REQ'(1) << grant : '0;
      busy        <= state_nx != IDLE;
      timeout_err <= tmo_hit;
      if (launch) begin
        grant    <= pick;
        eng_op   <= req_op[int'(pick)*OP_W +: OP_W];
        eng_data <= req_data[int'(pick)*DATA_W +: DATA_W];
      end
      if (state == ISSUE) last_grant <= grant;
    end
  end
endmodule

// File: tb/tb_ll_op_arbiter.sv
// tb_ll_op_arbiter: directed table, hand sequences and randomized run against a cycle-level model.
module tb_ll_op_arbiter;
  logic clk = 1'b0, reset;
  logic [3:0] req_valid, req_ready, rsp_done;
  logic [7:0] req_op;
  logic [31:0] req_data;
  logic eng_start, eng_done, busy, timeout_err;
  logic [1:0] eng_op;
  logic [7:0] eng_data;

  ll_op_arbiter #(.NUM_REQ(4), .OP_W(2), .DATA_W(8), .TIMEOUT_CYC(10)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
    .req_ready(req_ready), .rsp_done(rsp_done), .eng_start(eng_start), .eng_op(eng_op),
    .eng_data(eng_data), .eng_done(eng_done), .busy(busy), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!reset)
      for (int i = 0; i < 4; i++)
        assert (!(req_ready[i] && !req_valid[i]))
          else $error("protocol: req_valid[%0d] low during its accept cycle", i);

  typedef struct { logic [3:0] valid; logic [7:0] ops; logic [31:0] data; int g; } vec_t;
  vec_t tbl[8];
  int vectors = 0, miscompares = 0;
  int c = 0, rr, free_c, dcnt, g_cur, fixed_delay;
  bit mbusy, pend_done, rand_mode;
  logic [3:0] want, pv, last_ready;
  int order[$];
  int t2[6] = '{0, 1, 2, 3, 0, 1};

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, c, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    c++;
  endtask

  function automatic int rr_pick(logic [3:0] v, int last);
    for (int k = 1; k <= 4; k++)
      if (v[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    eng_done = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    mbusy = 0;
    pend_done = 0;
    rr = 3;
    pv = '0;
    last_ready = '0;
    free_c = c;
    order.delete();
  endtask

  // model: arbiter accepts the request pattern of the previous cycle when idle and not in a response cycle
  task automatic step();
    int g;
    bit launched;
    tick();
    launched = 0;
    if (!mbusy && pv != 0 && c - 1 >= free_c) begin
      g = rr_pick(pv, rr);
      chk("rr_start", eng_start, 1);
      chk("rr_ready", req_ready, 32'(1) << g);
      chk("rr_op", eng_op, req_op[g*2 +: 2]);
      chk("rr_data", eng_data, req_data[g*8 +: 8]);
      rr = g;
      g_cur = g;
      mbusy = 1;
      launched = 1;
      order.push_back(g);
      dcnt = rand_mode ? int'($urandom_range(1, 5)) : fixed_delay;
    end else begin
      chk("rr_start", eng_start, 0);
      chk("rr_ready", req_ready, 0);
    end
    if (pend_done) begin
      chk("rr_rsp", rsp_done, 32'(1) << g_cur);
      mbusy = 0;
      free_c = c + 1;
    end else chk("rr_rsp", rsp_done, 0);
    chk("rr_busy", busy, mbusy);
    chk("rr_terr", timeout_err, 0);
    eng_done = 1'b0;
    pend_done = 0;
    if (mbusy && !launched) begin
      dcnt--;
      if (dcnt == 0) begin
        eng_done = 1'b1;
        pend_done = 1;
      end
    end else if (!mbusy && rand_mode && $urandom_range(0, 7) == 0) eng_done = 1'b1;
    for (int i = 0; i < 4; i++)
      if (!(req_valid[i] && !last_ready[i])) begin
        req_valid[i] = rand_mode ? ($urandom_range(0, 2) == 0) : want[i];
        req_op[i*2 +: 2] = 2'($urandom);
        req_data[i*8 +: 8] = 8'($urandom);
      end
    last_ready = req_ready;
    pv = req_valid;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g;
    reset = 1'b1; req_valid = '0; req_op = '0; req_data = '0; eng_done = 1'b0;
    rand_mode = 0; want = '0; fixed_delay = 2;
    tbl[0] = '{4'b0010, 8'b00_00_10_00, 32'h0000A500, 1};
    tbl[1] = '{4'b0101, 8'hE4, 32'h44332211, 2};
    tbl[2] = '{4'b1001, 8'h1B, 32'hDEADBEEF, 3};
    tbl[3] = '{4'b1111, 8'h6C, 32'h0F1E2D3C, 0};
    tbl[4] = '{4'b0001, 8'h03, 32'h000000FF, 0};
    tbl[5] = '{4'b1100, 8'h9A, 32'h5A6B7C8D, 2};
    tbl[6] = '{4'b0010, 8'h55, 32'h00990000, 1};
    tbl[7] = '{4'b1010, 8'hC6, 32'h12345678, 3};
    do_reset();
    chk("rst_start", eng_start, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp", rsp_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_op", eng_op, 0);
    chk("rst_data", eng_data, 0);
    chk("rst_terr", timeout_err, 0);
    foreach (tbl[i]) begin
      g = tbl[i].g;
      req_op = tbl[i].ops; req_data = tbl[i].data; req_valid = tbl[i].valid;
      tick();
      chk($sformatf("tbl%0d_start", i), eng_start, 1);
      chk($sformatf("tbl%0d_ready", i), req_ready, 32'(1) << g);
      chk($sformatf("tbl%0d_op", i), eng_op, tbl[i].ops[g*2 +: 2]);
      chk($sformatf("tbl%0d_data", i), eng_data, tbl[i].data[g*8 +: 8]);
      chk($sformatf("tbl%0d_busy", i), busy, 1);
      tick();
      req_valid = '0;
      chk($sformatf("tbl%0d_pulse", i), eng_start, 0);
      tick(); tick();
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      chk($sformatf("tbl%0d_rsp", i), rsp_done, 32'(1) << g);
      chk($sformatf("tbl%0d_idle", i), busy, 0);
      tick();
      chk($sformatf("tbl%0d_rsp_end", i), rsp_done, 0);
    end
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    chk("stray_rsp", rsp_done, 0);
    chk("stray_busy", busy, 0);
    tick();
    chk("stray_start", eng_start, 0);
    do_reset();
    req_op = 8'b0000_1100; req_data = 32'h00007700; req_valid = 4'b0010;
    tick();
    chk("t4_ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    tick();
    reset = 1'b1; eng_done = 1'b1;
    tick();
    reset = 1'b0; eng_done = 1'b0;
    chk("t4_rsp", rsp_done, 0);
    chk("t4_busy", busy, 0);
    chk("t4_start", eng_start, 0);
    chk("t4_op", eng_op, 0);
    chk("t4_data", eng_data, 0);
    req_op = 8'b01_00_00_11; req_data = 32'h99000033; req_valid = 4'b1001;
    tick();
    chk("t4_regrant", req_ready, 4'b0001);
    chk("t4_op2", eng_op, 3);
    chk("t4_data2", eng_data, 8'h33);
    tick();
    req_valid = '0;
    tick();
    chk("t4_no_rsp", rsp_done, 0);
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    chk("t4_rsp2", rsp_done, 4'b0001);
    do_reset();
    want = 4'hF; fixed_delay = 2;
    for (int k = 0; k < 200 && order.size() < 6; k++) step();
    chk("t2_count", order.size() >= 6, 1);
    if (order.size() >= 6)
      for (int i = 0; i < 6; i++) chk($sformatf("t2_grant%0d", i), order[i], t2[i]);
    do_reset();
    want = 4'b0100;
    for (int k = 0; k < 100 && order.size() < 1; k++) step();
    want = 4'b1101;
    for (int k = 0; k < 100 && order.size() < 3; k++) step();
    chk("t3_count", order.size() >= 3, 1);
    if (order.size() >= 3) begin
      chk("t3_first", order[0], 2);
      chk("t3_wrap3", order[1], 3);
      chk("t3_wrap0", order[2], 0);
    end
    do_reset();
    rand_mode = 1;
    for (int k = 0; k < 1500; k++) step();
    chk("rand_activity", order.size() > 50, 1);
    rand_mode = 0;
`ifdef LL_ARB_TIMEOUT_EN
    do_reset();
    req_op = 8'h30; req_data = 32'h00AB0000; req_valid = 4'b0100;
    tick();
    chk("t6_start", eng_start, 1);
    tick();
    req_valid = '0;
    for (int k = 2; k <= 10; k++) tick();
    chk("t6_pre_terr", timeout_err, 0);
    chk("t6_pre_busy", busy, 1);
    tick();
    chk("t6_terr", timeout_err, 1);
    chk("t6_rsp", rsp_done, 4'b0100);
    chk("t6_idle", busy, 0);
    tick();
    chk("t6_terr_end", timeout_err, 0);
    req_valid = 4'b0100;
    tick();
    chk("t6b_start", eng_start, 1);
    tick();
    req_valid = '0;
    for (int k = 2; k <= 10; k++) tick();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    chk("t6b_terr", timeout_err, 0);
    chk("t6b_rsp", rsp_done, 4'b0100);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
